opcode_encoder: RTL and testbench

//  Inverse of the 8-bit opcode decode: takes a 27-bit decoded control vector and re-encodes it into the 8-bit opcode.

---
 rtl/opc_enc_pkg.sv | 50 +++++
 rtl/opc_enc_core.sv | 35 +++
 rtl/opcode_encoder.sv | 114 +++++++++++
 tb/tb_opcode_encoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opc_enc_pkg.sv
// Shared constants, FIFO state type and encode helpers for the opcode encoder.
package opc_enc_pkg;

  localparam int unsigned CTRL_W = 27;
  localparam int unsigned OP_W   = 23;

  localparam int unsigned F0_BIT = 23;
  localparam int unsigned F1_BIT = 24;
  localparam int unsigned F2_BIT = 25;
  localparam int unsigned F3_BIT = 26;

  localparam int unsigned G_LOW_BASE = 1;
  localparam int unsigned G_MID_BASE = 5;
  localparam int unsigned G_HI_BASE  = 15;
  localparam int unsigned G_B17      = 17;
  localparam int unsigned G_B18      = 18;
  localparam int unsigned G_TOP_BASE = 19;

  localparam logic [3:0] NIB_ZERO = 4'd0;
  localparam logic [3:0] NIB_LOW  = 4'd1;
  localparam logic [3:0] NIB_HI   = 4'd12;
  localparam logic [3:0] NIB_B17  = 4'd13;
  localparam logic [3:0] NIB_B18  = 4'd14;
  localparam logic [3:0] NIB_TOP  = 4'd15;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_t;

  function automatic logic [3:0] op_nibble(input int unsigned k);
    if (k < G_LOW_BASE)      return NIB_ZERO;
    else if (k < G_MID_BASE) return NIB_LOW;
    else if (k < G_HI_BASE)  return 4'(k - 3);
    else if (k < G_B17)      return NIB_HI;
    else if (k == G_B17)     return NIB_B17;
    else if (k == G_B18)     return NIB_B18;
    else                     return NIB_TOP;
  endfunction

  // Groups sharing one nibble are told apart by the low opcode field bits.
  function automatic logic field_ok(input int unsigned k, input logic f2, input logic f3);
    if (k >= G_LOW_BASE && k < G_MID_BASE)     return {f2, f3} == 2'(k - G_LOW_BASE);
    else if (k >= G_HI_BASE && k < G_B17)      return f3 == 1'(k - G_HI_BASE);
    else if (k >= G_TOP_BASE && k < OP_W)      return {f2, f3} == 2'(k - G_TOP_BASE);
    else                                       return 1'b1;
  endfunction

endpackage

// File: rtl/opc_enc_core.sv
// Combinational control-vector to opcode encode; OPC_ENC_CHECK_EN enables rejection checks.
module opc_enc_core
  import opc_enc_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl,
  output logic [7:0]        opcode,
  output logic              reject
);

  logic [OP_W-1:0] op;
  logic [4:0]      sel;
  logic            found;

  assign op = ctrl[OP_W-1:0];

  // Lowest set op bit selects the upper nibble; all-zero op selects bit 0's nibble.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < OP_W; i++) begin
      if (op[i] && !found) begin
        sel   = 5'(i);
        found = 1'b1;
      end
    end
    opcode = {op_nibble(32'(sel)), ctrl[F0_BIT], ctrl[F1_BIT], ctrl[F2_BIT], ctrl[F3_BIT]};
  end

`ifdef OPC_ENC_CHECK_EN
  always_comb reject = !$onehot(op) || !field_ok(32'(sel), ctrl[F2_BIT], ctrl[F3_BIT]);
`else
  assign reject = 1'b0;
`endif

endmodule

// File: rtl/opcode_encoder.sv
// Registered opcode encoder with output FIFO, write-address counter and error counter.
// Define OPC_ENC_CHECK_EN to reject malformed control vectors and count them.
module opcode_encoder
  import opc_enc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic                 addr_load,
  input  logic [ADDR_W-1:0]    addr_load_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_opcode,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FIFO_DEPTH - 1);

  fifo_state_t       state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [7:0]        mem_opc  [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_cnt, entry_addr;
  logic [7:0]        enc_opcode;
  logic              enc_reject;
  logic              accept, push, pop;

  opc_enc_core u_core (
    .ctrl   (in_ctrl),
    .opcode (enc_opcode),
    .reject (enc_reject)
  );

  assign accept     = in_valid & in_ready;
  assign push       = accept & ~enc_reject;
  assign pop        = out_valid & out_ready;
  assign entry_addr = addr_load ? addr_load_val : addr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FIFO_EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_opc[i]  <= '0;
        mem_addr[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        mem_opc[wr_ptr]  <= enc_opcode;
        mem_addr[wr_ptr] <= entry_addr;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FIFO_EMPTY:   if (push) state_nxt = FIFO_PARTIAL;
      FIFO_PARTIAL: begin
        if (push && !pop && count == LAST)          state_nxt = FIFO_FULL;
        else if (pop && !push && count == CNT_W'(1)) state_nxt = FIFO_EMPTY;
      end
      FIFO_FULL:    if (pop) state_nxt = FIFO_PARTIAL;
      default:      state_nxt = FIFO_EMPTY;
    endcase
  end

  always_comb begin
    in_ready   = (state != FIFO_FULL);
    out_valid  = (state != FIFO_EMPTY);
    out_opcode = mem_opc[rd_ptr];
    out_addr   = mem_addr[rd_ptr];
  end

  // addr_load applies even to a rejected transfer, but only a push advances past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         addr_cnt <= '0;
    else if (push)      addr_cnt <= entry_addr + ADDR_W'(1);
    else if (addr_load) addr_cnt <= addr_load_val;
  end

`ifdef OPC_ENC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= accept & enc_reject;
      if (accept && enc_reject && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`else
  assign err_pulse = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_opcode_encoder.sv
// Scoreboard bench for opcode_encoder: directed cases plus random traffic against a table model.
module tb_opcode_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_ctrl;
  logic        addr_load;
  logic [7:0]  addr_load_val;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [7:0]  out_addr;
  logic        err_pulse;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  opcode_encoder #(.ADDR_W(8), .FIFO_DEPTH(2), .ERR_CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl       (in_ctrl),
    .addr_load     (addr_load),
    .addr_load_val (addr_load_val),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_addr      (out_addr),
    .err_pulse     (err_pulse),
    .err_count     (err_count)
  );

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] addr;
  } item_t;

  item_t       sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  m_addr;
  int unsigned m_err;
  bit          pend_err;

  // Upper opcode nibble for each op bit 0..22.
  int unsigned hi_tab [23] = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                               12, 12, 13, 14, 15, 15, 15, 15};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] mk(input int unsigned k, input logic [3:0] f);
    logic [26:0] c;
    c     = '0;
    c[k]  = 1'b1;
    c[26] = f[3];
    c[25] = f[2];
    c[24] = f[1];
    c[23] = f[0];
    return c;
  endfunction

  function automatic void model(input logic [26:0] c, output bit rej, output logic [7:0] opc);
    int low;
    low = -1;
    for (int i = 22; i >= 0; i--) if (c[i]) low = i;
    opc[3:0] = {c[23], c[24], c[25], c[26]};
    opc[7:4] = (low < 0) ? 4'd0 : 4'(hi_tab[low]);
    rej = 1'b0;
`ifdef OPC_ENC_CHECK_EN
    if ($countones(c[22:0]) != 1)       rej = 1'b1;
    else if (low >= 1 && low <= 4)      rej = (int'({c[25], c[26]}) != low - 1);
    else if (low == 15 || low == 16)    rej = (int'(c[26]) != low - 15);
    else if (low >= 19)                 rej = (int'({c[25], c[26]}) != low - 19);
`endif
  endfunction

  // One clock of stimulus; the expected entry is queued when the transfer is certain.
  task automatic step(input bit v, input logic [26:0] c, input bit ld, input logic [7:0] lv,
                      input bit ordy, output bit acc);
    bit         rej;
    logic [7:0] opc;
    logic [7:0] a;
    @(posedge clk);
    #1;
    in_valid      = v;
    in_ctrl       = c;
    addr_load     = ld;
    addr_load_val = lv;
    out_ready     = ordy;
    @(negedge clk);
    chk("err_pulse", 32'(err_pulse), 32'(pend_err));
    chk("err_count", 32'(err_count), m_err);
    pend_err = 1'b0;
    acc = v && in_ready;
    if (acc) begin
      model(c, rej, opc);
      if (rej) begin
        pend_err = 1'b1;
        if (m_err < 255) m_err++;
        if (ld) m_addr = lv;
      end else begin
        a = ld ? lv : m_addr;
        sb.push_back('{opc: opc, addr: a});
        m_addr = a + 8'd1;
      end
    end else if (ld) begin
      m_addr = lv;
    end
  endtask

  task automatic idle(input bit ordy, input int unsigned n);
    bit acc;
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, ordy, acc);
  endtask

  task automatic one_shot(input string name, input logic [26:0] c, input logic [7:0] exp);
    bit acc;
    step(1'b1, c, 1'b0, '0, 1'b0, acc);
    chk({name, "_accept"}, 32'(acc), 1);
    step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk({name, "_valid"}, 32'(out_valid), 1);
    chk({name, "_opcode"}, 32'(out_opcode), 32'(exp));
  endtask

  // Monitor: compares each popped head against the scoreboard and checks hold stability.
  initial begin : monitor
    bit         hold;
    logic [7:0] h_opc, h_addr;
    item_t      e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_opcode", 32'(out_opcode), 32'(h_opc));
        chk("hold_addr", 32'(out_addr), 32'(h_addr));
      end
      hold   = out_valid && !out_ready;
      h_opc  = out_opcode;
      h_addr = out_addr;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got opcode 0x%0h with no entry expected at %0t", out_opcode, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_opcode", 32'(out_opcode), 32'(e.opc));
          chk("sb_addr", 32'(out_addr), 32'(e.addr));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit          acc;
    logic [7:0]  saved;
    logic [26:0] c;
    int          j;
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; addr_load = 1'b0;
    addr_load_val = '0; out_ready = 1'b0;
    m_addr = '0; m_err = 0; pend_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_opcode", 32'(out_opcode), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_count", 32'(err_count), 0);
    rst_n = 1'b1;

    step(1'b1, mk(0, 4'h0), 1'b0, '0, 1'b0, acc);
    chk("t1_accept", 32'(acc), 1);
    step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk("t1_valid_next", 32'(out_valid), 1);
    chk("t1_opcode", 32'(out_opcode), 32'h00);
    chk("t1_addr", 32'(out_addr), 32'h00);

    one_shot("t2a", mk(3, 4'b0100), 8'h12);
    one_shot("t2b", mk(16, 4'b1000), 8'hC1);
    one_shot("t2c", mk(22, 4'b1100), 8'hF3);
    one_shot("t2d", mk(14, 4'b0000), 8'hB0);

    step(1'b1, mk(5, 4'h0), 1'b1, 8'h00, 1'b0, acc);
    step(1'b1, mk(6, 4'h0), 1'b0, '0, 1'b0, acc);
    step(1'b1, mk(7, 4'h0), 1'b0, '0, 1'b0, acc);
    chk("t3_in_ready_full", 32'(in_ready), 0);
    for (int i = 0; i < 6 && !acc; i++) step(1'b1, mk(7, 4'h0), 1'b0, '0, 1'b1, acc);
    chk("t3_third_accepted", 32'(acc), 1);
    idle(1'b1, 4);

    step(1'b1, mk(8, 4'h0), 1'b1, 8'hFF, 1'b0, acc);
    step(1'b1, mk(9, 4'h0), 1'b0, '0, 1'b0, acc);
    chk("t4_addr_ff", 32'(out_addr), 32'hFF);
    idle(1'b1, 1);
    step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk("t4_addr_wrap", 32'(out_addr), 32'h00);
    idle(1'b1, 2);

`ifdef OPC_ENC_CHECK_EN
    saved = m_addr;
    step(1'b1, mk(3, 4'b0000), 1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk("t5_err_pulse", 32'(err_pulse), 1);
    chk("t5_err_count1", 32'(err_count), 1);
    chk("t5_no_push", 32'(out_valid), 0);
    step(1'b1, 27'h0, 1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b0, '0, 1'b0, acc);
    chk("t5_err_count2", 32'(err_count), 2);
    step(1'b1, mk(0, 4'h0), 1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b0, '0, 1'b0, acc);
    chk("t5_addr_kept", 32'(out_addr), 32'(saved));
    idle(1'b1, 2);
`endif

    for (int i = 0; i < 400; i++) begin
      c = mk($urandom_range(0, 22), 4'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        j = int'($urandom_range(0, 22));
        c[j] = ~c[j];
      end
      step($urandom_range(0, 3) != 0, c, $urandom_range(0, 15) == 0, 8'($urandom),
           $urandom_range(0, 2) != 0, acc);
    end
    idle(1'b1, 4);

    step(1'b1, mk(1, 4'b0000), 1'b0, '0, 1'b0, acc);
    step(1'b1, mk(2, 4'b1000), 1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b0, '0, 1'b0, acc);
    chk("t6_pre_valid", 32'(out_valid), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_out_addr", 32'(out_addr), 0);
    chk("t6_out_opcode", 32'(out_opcode), 0);
    chk("t6_err_count", 32'(err_count), 0);
    sb.delete();
    m_addr = '0; m_err = 0; pend_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, mk(10, 4'h5), 1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk("t6_addr_restart", 32'(out_addr), 0);

    for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) idle(1'b1, 1);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_out_valid", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
